// File: rtl/processor_top.sv
// Minimal accumulator processor board top: fixed 16-word ROM program executed one
// instruction per clock, LED output port, loop counter, and an 8-digit multiplexed
// 7-segment display showing LED (digits 0-3) and the loop count (digits 4-7).
module processor_top #(
  parameter int unsigned REFRESH_LOG2 = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic [7:0]  SevenSegAn,
  output logic [6:0]  SevenSegCat
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDSW = 4'h1,
    OP_LDI  = 4'h2,
    OP_ADDI = 4'h3,
    OP_OUT  = 4'h4,
    OP_INC  = 4'h5,
    OP_JMP  = 4'h6,
    OP_BZ   = 4'h7
  } opcode_t;

  logic [3:0]              pc;
  logic [15:0]             acc;
  logic [15:0]             cnt;
  logic [15:0]             instr;
  logic [3:0]              op;
  logic [11:0]             imm;
  logic [REFRESH_LOG2-1:0] scan;
  logic [2:0]              idx;
  logic [15:0]             word;
  logic [3:0]              nib;

  // Program ROM: read SW, drive LED, count the loop, jump back; rest is NOP
  always_comb begin
    instr = '0;
    case (pc)
      4'd0:    instr = {OP_LDSW, 12'h000};
      4'd1:    instr = {OP_OUT,  12'h000};
      4'd2:    instr = {OP_INC,  12'h000};
      4'd3:    instr = {OP_JMP,  12'h000};
      default: instr = {OP_NOP,  12'h000};
    endcase
  end

  assign op  = instr[15:12];
  assign imm = instr[11:0];

  // Instruction execution; opcodes 8-F fall through as NOP
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc  <= '0;
      acc <= '0;
      cnt <= '0;
      LED <= '0;
    end else begin
      pc <= pc + 4'd1;
      case (op)
        OP_LDSW: acc <= SW;
        OP_LDI:  acc <= {4'b0000, imm};
        OP_ADDI: acc <= acc + {4'b0000, imm};
        OP_OUT:  LED <= acc;
        OP_INC:  cnt <= cnt + 16'd1;
        OP_JMP:  pc  <= imm[3:0];
        OP_BZ:   if (acc == '0) pc <= imm[3:0];
        default: ;
      endcase
    end
  end

  // Digit scan: advance the digit index once per 2**REFRESH_LOG2 clocks
  always_ff @(posedge CLK) begin
    if (Reset) begin
      scan <= '0;
      idx  <= '0;
    end else begin
      scan <= scan + 1'b1;
      if (scan == '1) idx <= idx + 3'd1;
    end
  end

  // Anode and cathodes are both decoded from registered state only, so they
  // switch on the same edge and no digit shows its neighbour's segments
  always_comb begin
    word        = idx[2] ? cnt : LED;
    nib         = word[{idx[1:0], 2'b00} +: 4];
    SevenSegAn  = ~(8'b0000_0001 << idx);
    SevenSegCat = 7'h40;
    case (nib)
      4'h0: SevenSegCat = 7'h40;
      4'h1: SevenSegCat = 7'h79;
      4'h2: SevenSegCat = 7'h24;
      4'h3: SevenSegCat = 7'h30;
      4'h4: SevenSegCat = 7'h19;
      4'h5: SevenSegCat = 7'h12;
      4'h6: SevenSegCat = 7'h02;
      4'h7: SevenSegCat = 7'h78;
      4'h8: SevenSegCat = 7'h00;
      4'h9: SevenSegCat = 7'h10;
      4'hA: SevenSegCat = 7'h08;
      4'hB: SevenSegCat = 7'h03;
      4'hC: SevenSegCat = 7'h46;
      4'hD: SevenSegCat = 7'h21;
      4'hE: SevenSegCat = 7'h06;
      4'hF: SevenSegCat = 7'h0E;
      default: SevenSegCat = 7'h40;
    endcase
  end

endmodule

// File: tb/tb_processor_top.sv
// Scoreboard bench for processor_top: the driver applies SW/Reset each clock and
// pushes the expected LED/display/count from a loop-level reference model; a
// monitor on the falling edge pops and compares.
module tb_processor_top;

  localparam int unsigned RL2 = 2;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] SW;
  logic [15:0] LED;
  logic [7:0]  SevenSegAn;
  logic [6:0]  SevenSegCat;

  processor_top #(.REFRESH_LOG2(RL2)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .SW          (SW),
    .LED         (LED),
    .SevenSegAn  (SevenSegAn),
    .SevenSegCat (SevenSegCat)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  cat;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // Reference model: edges since reset, last sampled SW, LED and loop count
  int unsigned k;
  logic [15:0] m_sample;
  logic [15:0] m_led;
  logic [15:0] m_cnt;

  logic [6:0] font [16];

  initial begin
    font[0]  = 7'h40; font[1]  = 7'h79; font[2]  = 7'h24; font[3]  = 7'h30;
    font[4]  = 7'h19; font[5]  = 7'h12; font[6]  = 7'h02; font[7]  = 7'h78;
    font[8]  = 7'h00; font[9]  = 7'h10; font[10] = 7'h08; font[11] = 7'h03;
    font[12] = 7'h46; font[13] = 7'h21; font[14] = 7'h06; font[15] = 7'h0E;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t expected_now();
    exp_t        e;
    int unsigned d;
    logic [15:0] w;
    d     = (k >> RL2) % 8;
    w     = (d < 4) ? m_led : m_cnt;
    e.led = m_led;
    e.cnt = m_cnt;
    e.an  = 8'hFF;
    e.an[d] = 1'b0;
    e.cat = font[(w >> (4 * (d % 4))) & 16'h000F];
    return e;
  endfunction

  // One clock: apply inputs, advance the model by the program's 4-step loop
  // (read SW, show it, count, jump back), optionally preload the count.
  task automatic step(input logic rst, input logic [15:0] sw, input logic preload);
    Reset = rst;
    SW    = sw;
    @(posedge CLK);
    #1;
    if (rst) begin
      k        = 0;
      m_sample = '0;
      m_led    = '0;
      m_cnt    = '0;
    end else begin
      case (k % 4)
        0: m_sample = sw;
        1: m_led    = m_sample;
        2: m_cnt    = m_cnt + 16'd1;
        default: ;
      endcase
      k++;
    end
    if (preload) begin
      force dut.cnt = 16'hFFFF;
      #1;
      release dut.cnt;
      m_cnt = 16'hFFFF;
    end
    q.push_back(expected_now());
  endtask

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("led", LED, e.led);
        check("anode", {8'h00, SevenSegAn}, {8'h00, e.an});
        check("cathode", {9'h000, SevenSegCat}, {9'h000, e.cat});
        check("cnt", dut.cnt, e.cnt);
      end
    end
  end

  initial begin
    Reset    = 1'b1;
    SW       = 16'h00F0;
    k        = 0;
    m_sample = '0;
    m_led    = '0;
    m_cnt    = '0;

    repeat (3) step(1'b1, 16'h00F0, 1'b0);
    repeat (100) step(1'b0, 16'h00F0, 1'b0);
    check("cnt_after_100", dut.cnt, 16'd25);

    repeat (20) step(1'b0, 16'h000F, 1'b0);
    repeat (200) step(1'b0, 16'($urandom()), 1'b0);

    step(1'b1, 16'h1234, 1'b0);
    repeat (40) step(1'b0, 16'h00F0, 1'b0);

    step(1'b0, 16'h00F0, 1'b1);
    repeat (80) step(1'b0, 16'h00F0, 1'b0);

    repeat (300) step(($urandom_range(0, 63) == 0), 16'($urandom()), 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
